// File: rtl/axilite_s_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS bus-writable registers with
// per-register read-only override, byte strobes and per-register commit strobes.
module axilite_s_regbank #(
  parameter int unsigned          ADDR_WIDTH = 15,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
  input  logic                            axi_aclk,
  input  logic                            axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]           awaddr,
  input  logic                            awvalid,
  output logic                            awready,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic [DATA_WIDTH/8-1:0]         wstrb,
  input  logic                            wvalid,
  output logic                            wready,
  output logic [1:0]                      bresp,
  output logic                            bvalid,
  input  logic                            bready,
  input  logic [ADDR_WIDTH-1:0]           araddr,
  input  logic                            arvalid,
  output logic                            arready,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic [1:0]                      rresp,
  output logic                            rvalid,
  input  logic                            rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0]  reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]  reg_ro_d,
  output logic [NUM_REGS-1:0]             wr_pulse
);

  localparam int unsigned         STRB_W      = DATA_WIDTH / 8;
  localparam int unsigned         OFF_BITS    = $clog2(STRB_W);
  localparam int unsigned         IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
  localparam logic [1:0]          RESP_OKAY   = 2'b00;
  localparam logic [1:0]          RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> OFF_BITS) < NUM_REGS_A;
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] word;
    word = addr >> OFF_BITS;
    return word[IDX_W-1:0];
  endfunction

  // Write path state
  w_state_t               w_state, w_state_n;
  logic                   aw_held, aw_held_n;
  logic [ADDR_WIDTH-1:0]  aw_addr_q, aw_addr_n;
  logic                   w_held, w_held_n;
  logic [DATA_WIDTH-1:0]  w_data_q, w_data_n;
  logic [STRB_W-1:0]      w_strb_q, w_strb_n;
  logic                   awready_n, wready_n, bvalid_n;
  logic [1:0]             bresp_n;
  logic [NUM_REGS-1:0]    wr_pulse_n;
  logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]  regs_n [NUM_REGS];

  logic                   aw_hs, w_hs, aw_have, w_have, cmt_ok;
  logic [ADDR_WIDTH-1:0]  cmt_addr;
  logic [DATA_WIDTH-1:0]  cmt_data;
  logic [STRB_W-1:0]      cmt_strb;
  logic [IDX_W-1:0]       cmt_idx;

  // Read path state
  r_state_t               r_state, r_state_n;
  logic                   arready_n, rvalid_n;
  logic [DATA_WIDTH-1:0]  rdata_n;
  logic [1:0]             rresp_n;
  logic [IDX_W-1:0]       ar_idx;
  logic                   ar_in;
  logic [DATA_WIDTH-1:0]  ro_words [NUM_REGS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      ro_words[i] = reg_ro_d[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  // Write next-state: the partner of an already-latched half can arrive
  // straight from the bus, so the commit source muxes held vs live values.
  always_comb begin
    w_state_n  = w_state;
    aw_held_n  = aw_held;
    aw_addr_n  = aw_addr_q;
    w_held_n   = w_held;
    w_data_n   = w_data_q;
    w_strb_n   = w_strb_q;
    awready_n  = awready;
    wready_n   = wready;
    bvalid_n   = bvalid;
    bresp_n    = bresp;
    wr_pulse_n = '0;
    regs_n     = regs_q;

    aw_hs    = awvalid & awready;
    w_hs     = wvalid & wready;
    aw_have  = aw_held | aw_hs;
    w_have   = w_held | w_hs;
    cmt_addr = aw_held ? aw_addr_q : awaddr;
    cmt_data = w_held ? w_data_q : wdata;
    cmt_strb = w_held ? w_strb_q : wstrb;
    cmt_idx  = addr_index(cmt_addr);
    cmt_ok   = addr_in_range(cmt_addr) && !RO_MASK[cmt_idx];

    case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_n = 1'b1;
          aw_addr_n = awaddr;
        end
        if (w_hs) begin
          w_held_n = 1'b1;
          w_data_n = wdata;
          w_strb_n = wstrb;
        end
        if (aw_have && w_have) begin
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          awready_n = 1'b0;
          wready_n  = 1'b0;
          bvalid_n  = 1'b1;
          w_state_n = W_RESP;
          if (cmt_ok) begin
            bresp_n             = RESP_OKAY;
            wr_pulse_n[cmt_idx] = 1'b1;
            for (int unsigned b = 0; b < STRB_W; b++) begin
              if (cmt_strb[b]) begin
                regs_n[cmt_idx][8*b +: 8] = cmt_data[8*b +: 8];
              end
            end
          end else begin
            bresp_n = RESP_SLVERR;
          end
        end else begin
          awready_n = !aw_have;
          wready_n  = !w_have;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // Write state register
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
      w_held    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= '0;
      wr_pulse  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      w_state   <= w_state_n;
      aw_held   <= aw_held_n;
      aw_addr_q <= aw_addr_n;
      w_held    <= w_held_n;
      w_data_q  <= w_data_n;
      w_strb_q  <= w_strb_n;
      awready   <= awready_n;
      wready    <= wready_n;
      bvalid    <= bvalid_n;
      bresp     <= bresp_n;
      wr_pulse  <= wr_pulse_n;
      regs_q    <= regs_n;
    end
  end

  // Read next-state: data is taken from regs_q, i.e. before any same-edge commit
  always_comb begin
    r_state_n = r_state;
    arready_n = arready;
    rvalid_n  = rvalid;
    rdata_n   = rdata;
    rresp_n   = rresp;
    ar_idx    = addr_index(araddr);
    ar_in     = addr_in_range(araddr);

    case (r_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (arvalid && arready) begin
          arready_n = 1'b0;
          rvalid_n  = 1'b1;
          r_state_n = R_DATA;
          if (!ar_in) begin
            rdata_n = '0;
            rresp_n = RESP_SLVERR;
          end else if (RO_MASK[ar_idx]) begin
            rdata_n = ro_words[ar_idx];
            rresp_n = RESP_OKAY;
          end else begin
            rdata_n = regs_q[ar_idx];
            rresp_n = RESP_OKAY;
          end
        end
      end
      R_DATA: begin
        if (rready) begin
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
          r_state_n = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  // Read state register
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
    end else begin
      r_state <= r_state_n;
      arready <= arready_n;
      rvalid  <= rvalid_n;
      rdata   <= rdata_n;
      rresp   <= rresp_n;
    end
  end

endmodule

// File: tb/tb_axilite_s_regbank.sv
// Self-checking bench for axilite_s_regbank (32-bit data, 16 registers, reg 3 read-only).
module tb_axilite_s_regbank;

  localparam logic [15:0] RO_TB = 16'h0008;

  logic          clk;
  logic          rst_n;
  logic [14:0]   awaddr;
  logic          awvalid, awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic [14:0]   araddr;
  logic          arvalid, arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid, rready;
  logic [511:0]  reg_q;
  logic [511:0]  reg_ro_d;
  logic [15:0]   wr_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model_regs [16];
  logic [31:0] ro_val     [16];

  axilite_s_regbank #(
    .ADDR_WIDTH (15),
    .DATA_WIDTH (32),
    .NUM_REGS   (16),
    .RO_MASK    (RO_TB)
  ) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .awaddr      (awaddr),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wvalid      (wvalid),
    .wready      (wready),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .reg_q       (reg_q),
    .reg_ro_d    (reg_ro_d),
    .wr_pulse    (wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    reg_ro_d = '0;
    for (int i = 0; i < 16; i++) reg_ro_d[i*32 +: 32] = ro_val[i];
  end

  // ---------------- reference model ----------------
  task automatic model_write(input logic [14:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output logic [15:0] pulse);
    int idx;
    logic [31:0] mask;
    idx = int'(addr) / 4;
    pulse = '0;
    if (idx >= 16 || RO_TB[idx]) begin
      resp = 2'b10;
    end else begin
      mask = '0;
      for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8*b));
      model_regs[idx] = (model_regs[idx] & ~mask) | (data & mask);
      resp = 2'b00;
      pulse[idx] = 1'b1;
    end
  endtask

  task automatic model_read(input logic [14:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int idx;
    idx = int'(addr) / 4;
    if (idx >= 16) begin
      data = '0; resp = 2'b10;
    end else if (RO_TB[idx]) begin
      data = ro_val[idx]; resp = 2'b00;
    end else begin
      data = model_regs[idx]; resp = 2'b00;
    end
  endtask

  function automatic logic [511:0] model_flat();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = model_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_regs[i] = '0;
  endtask

  // ---------------- bus drivers (called at a negedge) ----------------
  task automatic axi_write(input logic [14:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output logic [15:0] pulse_at, output logic [15:0] pulse_after);
    bit aw_done, w_done, aw_fire, w_fire;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    resp = 2'bxx; pulse_at = 'x; pulse_after = 'x;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && cyc < 60) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(negedge clk);
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      n_checks++;
      $display("FAIL write_handshake_timeout: addr %h aw_done %0d w_done %0d, required both 1", addr, aw_done, w_done);
      return;
    end
    pulse_at = wr_pulse;
    @(negedge clk);
    pulse_after = wr_pulse;
    repeat (b_dly) @(negedge clk);
    cyc = 0;
    while (!bvalid && cyc < 50) begin @(negedge clk); cyc++; end
    if (!bvalid) begin
      n_checks++;
      $display("FAIL bvalid_timeout: addr %h bvalid %b, required 1", addr, bvalid);
      return;
    end
    resp = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [14:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp,
                          output logic rv_first, output bit hold_ok);
    int cyc;
    data = 'x; resp = 'x; rv_first = 1'b0; hold_ok = 0;
    araddr = addr; arvalid = 1'b1; cyc = 0;
    while (!arready && cyc < 50) begin @(negedge clk); cyc++; end
    if (!arready) begin
      arvalid = 1'b0;
      n_checks++;
      $display("FAIL arready_timeout: arready %b, required 1", arready);
      return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    rv_first = rvalid;
    data = rdata; resp = rresp; hold_ok = 1;
    repeat (r_dly) begin
      @(negedge clk);
      if (rvalid !== 1'b1 || rdata !== data || rresp !== resp) hold_ok = 0;
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({awready, wready, arready} !== 3'b000) $display("FAIL reset_readies: got %b required 000", {awready, wready, arready}); else n_pass++;
    n_checks++; if ({bvalid, rvalid} !== 2'b00) $display("FAIL reset_valids: got %b required 00", {bvalid, rvalid}); else n_pass++;
    n_checks++; if ({bresp, rresp} !== 4'b0000) $display("FAIL reset_resps: got %b required 0000", {bresp, rresp}); else n_pass++;
    n_checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h required 0", rdata); else n_pass++;
    n_checks++; if (reg_q !== 512'h0 || wr_pulse !== 16'h0) $display("FAIL reset_regs: got pulse %h required 0 (reg_q nonzero=%b)", wr_pulse, |reg_q); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++; if ({awready, wready, arready} !== 3'b000) $display("FAIL readies_before_edge: got %b required 000", {awready, wready, arready}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({awready, wready, arready} !== 3'b111) $display("FAIL readies_after_edge: got %b required 111", {awready, wready, arready}); else n_pass++;
  endtask

  task automatic test_aw_before_w();
    logic [1:0] resp, eresp; logic [15:0] p0, p1, ep;
    axi_write(15'h08, 32'hDEADBEEF, 4'hF, 0, 2, 0, resp, p0, p1);
    model_write(15'h08, 32'hDEADBEEF, 4'hF, eresp, ep);
    n_checks++; if (reg_q[2*32 +: 32] !== 32'hDEADBEEF) $display("FAIL aw_first_reg2: got %h required deadbeef", reg_q[2*32 +: 32]); else n_pass++;
    n_checks++; if (p0 !== 16'h0004) $display("FAIL aw_first_pulse: got %h required 0004", p0); else n_pass++;
    n_checks++; if (p1 !== 16'h0000) $display("FAIL aw_first_pulse_len: got %h required 0000", p1); else n_pass++;
    n_checks++; if (resp !== 2'b00) $display("FAIL aw_first_bresp: got %b required 00", resp); else n_pass++;
    n_checks++; if (bvalid !== 1'b0) $display("FAIL aw_first_bvalid_drop: got %b required 0", bvalid); else n_pass++;
  endtask

  task automatic test_strobe();
    logic [1:0] resp, eresp; logic [15:0] p0, p1, ep;
    axi_write(15'h04, 32'h11223344, 4'hF, 0, 0, 0, resp, p0, p1);
    model_write(15'h04, 32'h11223344, 4'hF, eresp, ep);
    axi_write(15'h04, 32'hAABBCCDD, 4'h5, 1, 0, 1, resp, p0, p1);
    model_write(15'h04, 32'hAABBCCDD, 4'h5, eresp, ep);
    n_checks++; if (reg_q[1*32 +: 32] !== 32'h11BB33DD) $display("FAIL strobe_reg1: got %h required 11bb33dd", reg_q[1*32 +: 32]); else n_pass++;
    n_checks++; if (reg_q !== model_flat()) $display("FAIL strobe_regfile: reg_q differs from model"); else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [15:0] p0, p1; logic [31:0] d; logic rv; bit hold;
    axi_write(15'h40, $urandom, 4'hF, 0, 0, 0, resp, p0, p1);
    n_checks++; if (resp !== 2'b10) $display("FAIL oor_bresp: got %b required 10", resp); else n_pass++;
    n_checks++; if (p0 !== 16'h0) $display("FAIL oor_pulse: got %h required 0000", p0); else n_pass++;
    n_checks++; if (reg_q !== model_flat()) $display("FAIL oor_regfile: reg_q changed"); else n_pass++;
    axi_read(15'h40, 0, d, resp, rv, hold);
    n_checks++; if (rv !== 1'b1) $display("FAIL oor_rvalid_latency: got %b required 1", rv); else n_pass++;
    n_checks++; if (d !== 32'h0) $display("FAIL oor_rdata: got %h required 0", d); else n_pass++;
    n_checks++; if (resp !== 2'b10) $display("FAIL oor_rresp: got %b required 10", resp); else n_pass++;
  endtask

  task automatic test_read_only();
    logic [1:0] resp; logic [15:0] p0, p1; logic [31:0] d; logic rv; bit hold;
    ro_val[3] = 32'h0000CAFE;
    axi_write(15'h0C, 32'h12345678, 4'hF, 0, 0, 0, resp, p0, p1);
    n_checks++; if (resp !== 2'b10) $display("FAIL ro_bresp: got %b required 10", resp); else n_pass++;
    n_checks++; if (p0 !== 16'h0 || reg_q !== model_flat()) $display("FAIL ro_no_commit: pulse %h required 0000 or reg_q changed", p0); else n_pass++;
    axi_read(15'h0C, 2, d, resp, rv, hold);
    n_checks++; if (d !== 32'h0000CAFE) $display("FAIL ro_rdata: got %h required 0000cafe", d); else n_pass++;
    n_checks++; if (resp !== 2'b00) $display("FAIL ro_rresp: got %b required 00", resp); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [1:0] resp, eresp, er; logic [15:0] p0, p1, ep; logic [31:0] d, ed; logic rv; bit hold;
    int cyc;
    axi_write(15'h00, 32'd5, 4'hF, 0, 0, 0, resp, p0, p1);
    model_write(15'h00, 32'd5, 4'hF, eresp, ep);
    cyc = 0;
    while (!(awready && wready && arready) && cyc < 20) begin @(negedge clk); cyc++; end
    model_read(15'h00, ed, er);
    model_write(15'h00, 32'd9, 4'hF, eresp, ep);
    awaddr = 15'h00; wdata = 32'd9; wstrb = 4'hF; araddr = 15'h00;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if ({bvalid, rvalid} !== 2'b11) $display("FAIL stall_valids cycle %0d: got %b required 11", k, {bvalid, rvalid}); else n_pass++;
      n_checks++; if (rdata !== ed || rresp !== er || bresp !== eresp) $display("FAIL stall_data cycle %0d: rdata %h rresp %b bresp %b required %h %b %b", k, rdata, rresp, bresp, ed, er, eresp); else n_pass++;
      @(negedge clk);
    end
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    n_checks++; if ({bvalid, rvalid} !== 2'b00) $display("FAIL stall_release: got %b required 00", {bvalid, rvalid}); else n_pass++;
    axi_read(15'h00, 0, d, resp, rv, hold);
    model_read(15'h00, ed, er);
    n_checks++; if (d !== ed) $display("FAIL sim_later_read: got %h required %h", d, ed); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp, eresp; logic [15:0] p0, p1, ep; logic [31:0] dat;
    int cyc;
    awaddr = 15'h10; awvalid = 1'b1; cyc = 0;
    while (!awready && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk);
    awvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) $display("FAIL midrst_ctrl: got %b required 00000", {awready, wready, arready, bvalid, rvalid}); else n_pass++;
    n_checks++; if ({bresp, rresp} !== 4'b0 || rdata !== 32'h0 || wr_pulse !== 16'h0) $display("FAIL midrst_data: resp %b rdata %h pulse %h required zeros", {bresp, rresp}, rdata, wr_pulse); else n_pass++;
    n_checks++; if (reg_q !== 512'h0) $display("FAIL midrst_regs: reg_q not cleared"); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dat = $urandom;
    axi_write(15'h14, dat, 4'hF, 3, 0, 0, resp, p0, p1);
    model_write(15'h14, dat, 4'hF, eresp, ep);
    n_checks++; if (resp !== 2'b00) $display("FAIL post_rst_bresp: got %b required 00", resp); else n_pass++;
    n_checks++; if (p0 !== ep) $display("FAIL post_rst_pulse: got %h required %h", p0, ep); else n_pass++;
    n_checks++; if (reg_q !== model_flat()) $display("FAIL post_rst_regfile: reg4 %h reg5 %h required %h %h", reg_q[4*32 +: 32], reg_q[5*32 +: 32], model_regs[4], model_regs[5]); else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] resp, eresp, er; logic [15:0] p0, p1, ep; logic [31:0] d, ed, dat; logic rv; bit hold;
    logic [14:0] addr; logic [3:0] strb;
    for (int n = 0; n < 60; n++) begin
      addr = 15'($urandom_range(0, 16'h47));
      if ($urandom_range(0, 1) == 0) begin
        dat  = $urandom;
        strb = 4'($urandom_range(0, 15));
        axi_write(addr, dat, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), resp, p0, p1);
        model_write(addr, dat, strb, eresp, ep);
        n_checks++; if (resp !== eresp) $display("FAIL rnd_bresp addr %h: got %b required %b", addr, resp, eresp); else n_pass++;
        n_checks++; if (p0 !== ep || p1 !== 16'h0) $display("FAIL rnd_pulse addr %h: got %h then %h required %h then 0000", addr, p0, p1, ep); else n_pass++;
        n_checks++; if (reg_q !== model_flat()) $display("FAIL rnd_regfile after write to %h", addr); else n_pass++;
      end else begin
        ro_val[3] = $urandom;
        axi_read(addr, $urandom_range(0, 3), d, resp, rv, hold);
        model_read(addr, ed, er);
        n_checks++; if (rv !== 1'b1) $display("FAIL rnd_rvalid_latency addr %h: got %b required 1", addr, rv); else n_pass++;
        n_checks++; if (d !== ed || resp !== er) $display("FAIL rnd_read addr %h: got %h/%b required %h/%b", addr, d, resp, ed, er); else n_pass++;
        n_checks++; if (!hold) $display("FAIL rnd_read_hold addr %h: got unstable rvalid/rdata required stable", addr); else n_pass++;
      end
    end
  endtask

  initial begin
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 16; i++) ro_val[i] = $urandom;
    model_reset();
    test_reset();
    test_aw_before_w();
    test_strobe();
    test_out_of_range();
    test_read_only();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
